// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with an in-order response queue.
//
// Issues sequential fetch requests to instruction memory, reserves a queue
// entry per accepted request, fills entries in order as responses return and
// presents the oldest filled entry to the consumer. A redirect flushes the
// queue, restarts fetch at redirect_pc and drains responses still in flight.
//
// Ports:
//   clk, rst_        clock, synchronous active-high reset
//   ena_pc           fetch enable (only gates new requests)
//   imem_req/addr    request to instruction memory, accepted with imem_ready
//   imem_rvalid/rdata in-order responses from instruction memory
//   redirect/_pc     flush and restart fetch at redirect_pc
//   inst_valid/inst/inst_pc/inst_ready  head of queue to consumer
//   count            reserved entries (filled + awaiting response)
module fetch_queue #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     INST_WIDTH = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     ena_pc,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [INST_WIDTH-1:0]    imem_rdata,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     inst_valid,
  output logic [INST_WIDTH-1:0]    inst,
  output logic [XLEN-1:0]          inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W      = $clog2(DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned ALIGN_BITS = $clog2(INST_WIDTH / 8);

  localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(INST_WIDTH / 8);
  localparam logic [XLEN-1:0]  ALIGN_MASK = ~(XLEN'((1 << ALIGN_BITS) - 1));
  localparam logic [CNT_W-1:0] FULL       = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                 state_q;
  logic [XLEN-1:0]        fetch_pc_q;
  logic [XLEN-1:0]        pc_q   [DEPTH];
  logic [INST_WIDTH-1:0]  inst_q [DEPTH];
  logic [DEPTH-1:0]       filled_q;
  logic [PTR_W-1:0]       head_q;
  logic [PTR_W-1:0]       tail_q;
  logic [PTR_W-1:0]       fill_q;     // oldest reserved-but-unfilled entry
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       unfilled_q;
  logic [CNT_W-1:0]       discard_q;  // in-flight responses to drop

  logic                   accept;
  logic                   fill;
  logic                   pop;
  logic                   drop;
  logic [CNT_W-1:0]       redir_sum;
  logic [CNT_W-1:0]       discard_d;
  state_t                 resume_state;

  assign imem_addr  = fetch_pc_q;
  assign count      = count_q;
  assign inst_valid = ~rst_ & filled_q[head_q];
  assign inst       = inst_q[head_q];
  assign inst_pc    = pc_q[head_q];

  always_comb begin
    imem_req     = ~rst_ & (state_q == FETCH) & ena_pc & (count_q < FULL) & ~redirect;
    accept       = imem_req & imem_ready;
    pop          = inst_valid & inst_ready & ~redirect;
    fill         = ~rst_ & imem_rvalid & (discard_q == '0) & (unfilled_q != '0) & ~redirect;
    drop         = imem_rvalid & (discard_q != '0);
    redir_sum    = discard_q + unfilled_q;
    resume_state = ena_pc ? FETCH : IDLE;
    discard_d    = discard_q;
    if (redirect) begin
      // A response arriving with the redirect belongs to the flushed stream.
      if (imem_rvalid && (redir_sum != '0)) discard_d = redir_sum - CNT_ONE;
      else                                  discard_d = redir_sum;
    end else if (drop) begin
      discard_d = discard_q - CNT_ONE;
    end
  end

  // Entry payload storage needs no reset; validity lives in filled_q.
  always_ff @(posedge clk) begin
    if (accept) pc_q[tail_q]   <= fetch_pc_q;
    if (fill)   inst_q[fill_q] <= imem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      filled_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      discard_q  <= '0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc & ALIGN_MASK;
      filled_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      discard_q  <= discard_d;
      state_q    <= (discard_d != '0) ? DRAIN : resume_state;
    end else begin
      discard_q <= discard_d;

      case (state_q)
        IDLE:    if (ena_pc)  state_q <= FETCH;
        FETCH:   if (!ena_pc) state_q <= IDLE;
        DRAIN:   if (discard_d == '0) state_q <= resume_state;
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        filled_q[tail_q] <= 1'b0;
        tail_q           <= tail_q + PTR_ONE;
        fetch_pc_q       <= fetch_pc_q + PC_STEP;
      end
      if (fill) begin
        filled_q[fill_q] <= 1'b1;
        fill_q           <= fill_q + PTR_ONE;
      end
      if (pop) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= head_q + PTR_ONE;
      end

      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase

      case ({accept, fill})
        2'b10:   unfilled_q <= unfilled_q + CNT_ONE;
        2'b01:   unfilled_q <= unfilled_q - CNT_ONE;
        default: unfilled_q <= unfilled_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with default parameters
// (XLEN=32, INST_WIDTH=32, DEPTH=4, RESET_PC=0).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_;
  logic        ena_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  count;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned fails  = 0;

  fetch_queue #(
    .XLEN       (32),
    .INST_WIDTH (32),
    .DEPTH      (4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .rst_        (rst_),
    .ena_pc      (ena_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .count       (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ = 1'b1; ena_pc = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    cyc();
    cyc();
    #1;
    check("rst_req",   imem_req,   1'b0);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_count", count,      3'd0);
    check("rst_addr",  imem_addr,  32'h0);

    // Streaming: one instruction per cycle after startup
    rst_ = 1'b0; imem_ready = 1'b1; inst_ready = 1'b1;
    #1 check("idle_no_req", imem_req, 1'b0);
    cyc();
    for (int k = 1; k <= 8; k++) begin
      imem_rvalid = (k >= 2);
      imem_rdata  = 32'hA000_0000 + 32'(4 * (k - 2));
      #1;
      check("stream_req",  imem_req,  1'b1);
      check("stream_addr", imem_addr, 32'(4 * (k - 1)));
      if (k >= 3) begin
        check("stream_valid", inst_valid, 1'b1);
        check("stream_pc",    inst_pc,    32'(4 * (k - 3)));
        check("stream_inst",  inst,       32'hA000_0000 + 32'(4 * (k - 3)));
        check("stream_count", count,      3'd2);
      end
      cyc();
    end
    ena_pc = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_001C;
    #1;
    check("stop_req",  imem_req, 1'b0);
    check("stop_pc",   inst_pc,  32'h18);
    check("stop_inst", inst,     32'hA000_0018);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    check("last_valid", inst_valid, 1'b1);
    check("last_pc",    inst_pc,    32'h1C);
    check("last_inst",  inst,       32'hA000_001C);
    cyc();
    #1;
    check("empty_count", count,      3'd0);
    check("empty_valid", inst_valid, 1'b0);

    // Backpressure: queue fills to DEPTH, one pop frees one request
    ena_pc = 1'b1; inst_ready = 1'b0;
    #1 check("idle2_req", imem_req, 1'b0);
    cyc();
    for (int j = 0; j < 4; j++) begin
      imem_rvalid = (j >= 1);
      imem_rdata  = 32'hB000_0000 + 32'(32 + 4 * (j - 1));
      #1;
      check("fill_req",  imem_req,  1'b1);
      check("fill_addr", imem_addr, 32'(32 + 4 * j));
      cyc();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hB000_002C;
    #1;
    check("full_req",   imem_req, 1'b0);
    check("full_count", count,    3'd4);
    cyc();
    imem_rvalid = 1'b0; inst_ready = 1'b1;
    #1;
    check("full_pop_req",   imem_req, 1'b0);
    check("full_pop_pc",    inst_pc,  32'h20);
    check("full_pop_count", count,    3'd4);
    cyc();
    inst_ready = 1'b0;
    #1;
    check("after_pop_req",   imem_req,  1'b1);
    check("after_pop_addr",  imem_addr, 32'h30);
    check("after_pop_count", count,     3'd3);
    check("after_pop_pc",    inst_pc,   32'h24);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'hB000_0030;
    #1;
    check("refull_req",   imem_req, 1'b0);
    check("refull_count", count,    3'd4);
    cyc();

    // Flush the full queue (nothing in flight)
    imem_rvalid = 1'b0; redirect = 1'b1; redirect_pc = 32'h10; inst_ready = 1'b1;
    #1 check("redir_req", imem_req, 1'b0);
    cyc();
    redirect = 1'b0; inst_ready = 1'b0;
    #1;
    check("flush_count", count,      3'd0);
    check("flush_valid", inst_valid, 1'b0);
    check("flush_addr",  imem_addr,  32'h10);
    check("flush_req",   imem_req,   1'b1);
    cyc();
    #1 check("out_addr1", imem_addr, 32'h14);
    cyc();
    #1 check("out_addr2", imem_addr, 32'h18);
    cyc();

    // Redirect with three requests outstanding, misaligned target
    redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    check("out3_count", count,     3'd3);
    check("out3_req",   imem_req,  1'b0);
    check("out3_addr",  imem_addr, 32'h1C);
    cyc();
    redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0010;
    #1;
    check("drain_addr",  imem_addr, 32'h100);
    check("drain_count", count,     3'd0);
    check("drain_req0",  imem_req,  1'b0);
    cyc();
    imem_rdata = 32'hDEAD_0014;
    #1 check("drain_req1", imem_req, 1'b0);
    cyc();
    imem_rdata = 32'hDEAD_0018;
    #1 check("drain_req2", imem_req, 1'b0);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    check("resume_req",   imem_req,   1'b1);
    check("resume_addr",  imem_addr,  32'h100);
    check("resume_valid", inst_valid, 1'b0);
    check("resume_count", count,      3'd0);
    cyc();
    #1;
    check("resume_addr2",  imem_addr, 32'h104);
    check("resume_count2", count,     3'd1);
    cyc();

    // Redirect coinciding with a response and a ready memory
    redirect = 1'b1; redirect_pc = 32'h200; imem_rvalid = 1'b1; imem_rdata = 32'hC000_0100;
    #1;
    check("coll_req",   imem_req,  1'b0);
    check("coll_count", count,     3'd2);
    check("coll_addr",  imem_addr, 32'h108);
    cyc();
    redirect = 1'b0; imem_rdata = 32'hC000_0104;
    #1;
    check("coll_empty", count,      3'd0);
    check("coll_valid", inst_valid, 1'b0);
    check("coll_addr2", imem_addr,  32'h200);
    check("coll_drain", imem_req,   1'b0);
    cyc();

    // Memory stalls for 5 cycles: address must hold
    imem_rvalid = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_req",  imem_req,  1'b1);
      check("stall_addr", imem_addr, 32'h200);
      cyc();
    end
    imem_ready = 1'b1;
    #1 check("stall_acc_addr", imem_addr, 32'h200);
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hE000_0200;
    #1;
    check("post_stall_addr",  imem_addr,  32'h204);
    check("post_stall_count", count,      3'd1);
    check("post_stall_valid", inst_valid, 1'b0);
    cyc();
    imem_rvalid = 1'b0; inst_ready = 1'b1;
    #1;
    check("stall_inst_valid", inst_valid, 1'b1);
    check("stall_inst_pc",    inst_pc,    32'h200);
    check("stall_inst",       inst,       32'hE000_0200);
    cyc();

    // PC wrap at top of address space
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1 check("wrap_pre_count", count, 3'd0);
    cyc();
    redirect = 1'b0; imem_ready = 1'b1;
    #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_req",  imem_req,  1'b1);
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hF000_0000;
    #1 check("wrap_next", imem_addr, 32'h0);
    cyc();
    imem_rvalid = 1'b0; inst_ready = 1'b1;
    #1;
    check("wrap_valid", inst_valid, 1'b1);
    check("wrap_pc",    inst_pc,    32'hFFFF_FFFC);
    check("wrap_inst",  inst,       32'hF000_0000);
    cyc();

    // Stray response with nothing outstanding is ignored
    inst_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    #1 check("stray_pre_count", count, 3'd0);
    cyc();
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    #1;
    check("stray_valid", inst_valid, 1'b0);
    check("stray_count", count,      3'd0);
    check("stray_req",   imem_req,   1'b1);
    check("stray_addr",  imem_addr,  32'h0);
    cyc();

    // Reset overrides a concurrent redirect
    imem_ready = 1'b0; rst_ = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    check("inrst_req",   imem_req, 1'b0);
    check("inrst_count", count,    3'd1);
    cyc();
    rst_ = 1'b0; redirect = 1'b0; ena_pc = 1'b0;
    #1;
    check("postrst_addr",  imem_addr,  32'h0);
    check("postrst_count", count,      3'd0);
    check("postrst_req",   imem_req,   1'b0);
    check("postrst_valid", inst_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
